// File: rtl/gtx_reset_seq.sv
// GTX transceiver reset sequencer: powers the CPLL down and up, waits for lock, pulses the
// TX reset, waits for reset-done, and retries on timeouts until a fault limit is reached.
module gtx_reset_seq #(
  parameter int unsigned PD_CYCLES    = 16,
  parameter int unsigned RST_CYCLES   = 4,
  parameter int unsigned LOCK_TIMEOUT = 50000,
  parameter int unsigned DONE_TIMEOUT = 50000,
  parameter int unsigned MAX_RETRY    = 8,
  parameter bit          AUTO_START   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cpll_lock,
  input  logic       tx_resetdone,
  output logic       cpll_pd,
  output logic       cpll_reset,
  output logic       gttx_reset,
  output logic       tx_userrdy,
  output logic       ready,
  output logic       fault,
  output logic [7:0] retry_cnt,
  output logic [2:0] state
);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StPd       = 3'd1;
  localparam logic [2:0] StCpllRst  = 3'd2;
  localparam logic [2:0] StWaitLock = 3'd3;
  localparam logic [2:0] StGtRst    = 3'd4;
  localparam logic [2:0] StWaitDone = 3'd5;
  localparam logic [2:0] StReady    = 3'd6;
  localparam logic [2:0] StFault    = 3'd7;

  localparam int unsigned MaxA     = (PD_CYCLES > RST_CYCLES) ? PD_CYCLES : RST_CYCLES;
  localparam int unsigned MaxB     = (LOCK_TIMEOUT > DONE_TIMEOUT) ? LOCK_TIMEOUT : DONE_TIMEOUT;
  localparam int unsigned MaxDwell = (MaxA > MaxB) ? MaxA : MaxB;
  localparam int unsigned CntW     = $clog2(MaxDwell + 1);

  // Dwell value seen on the last cycle of each timed state.
  localparam logic [CntW-1:0] PdLast   = CntW'(PD_CYCLES - 1);
  localparam logic [CntW-1:0] RstLast  = CntW'(RST_CYCLES - 1);
  localparam logic [CntW-1:0] LockLast = CntW'(LOCK_TIMEOUT - 1);
  localparam logic [CntW-1:0] DoneLast = CntW'(DONE_TIMEOUT - 1);

  logic [2:0]      state_q, state_d;
  logic [CntW-1:0] dwell_q, dwell_d;
  logic [7:0]      retry_q, retry_d, retry_inc;
  logic            lock_meta_q, lock_sync_q;
  logic            done_meta_q, done_sync_q;
  logic            fail;
  logic [5:0]      out_d;

  assign retry_inc = (retry_q == 8'hff) ? 8'hff : retry_q + 8'd1;

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    fail    = 1'b0;
    case (state_q)
      StIdle:     if (AUTO_START) state_d = StPd;
      StPd:       if (dwell_q == PdLast) state_d = StCpllRst;
      StCpllRst:  if (dwell_q == RstLast) state_d = StWaitLock;
      // Lock is tested first so it wins over a same-cycle timeout.
      StWaitLock: begin
        if (lock_sync_q)               state_d = StGtRst;
        else if (dwell_q >= LockLast)  fail = 1'b1;
      end
      StGtRst:    if (dwell_q == RstLast) state_d = StWaitDone;
      StWaitDone: begin
        if (done_sync_q)               state_d = StReady;
        else if (dwell_q >= DoneLast)  fail = 1'b1;
      end
      StReady: begin
        if (!lock_sync_q)              fail = 1'b1;
        else if (!done_sync_q)         state_d = StGtRst;
      end
      StFault:    state_d = StFault;
      default:    state_d = StIdle;
    endcase

    if (fail) begin
      retry_d = retry_inc;
      state_d = ({24'd0, retry_inc} >= MAX_RETRY) ? StFault : StPd;
    end

    if (start) begin
      state_d = StPd;
      retry_d = 8'd0;
    end
  end

  always_comb begin
    if (state_d != state_q || start) begin
      dwell_d = '0;
    end else if (dwell_q != '1) begin
      dwell_d = dwell_q + CntW'(1);
    end else begin
      dwell_d = dwell_q;
    end
  end

  // Outputs decoded from the next state so the registered values line up with state.
  always_comb begin
    out_d = 6'b111000;
    case (state_d)
      StIdle, StPd:        out_d = 6'b111000;
      StCpllRst:           out_d = 6'b011000;
      StWaitLock, StGtRst: out_d = 6'b001000;
      StWaitDone:          out_d = 6'b000100;
      StReady:             out_d = 6'b000110;
      StFault:             out_d = 6'b111001;
      default:             out_d = 6'b111000;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      dwell_q     <= '0;
      retry_q     <= 8'd0;
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
      done_meta_q <= 1'b0;
      done_sync_q <= 1'b0;
      {cpll_pd, cpll_reset, gttx_reset, tx_userrdy, ready, fault} <= 6'b111000;
    end else begin
      state_q     <= state_d;
      dwell_q     <= dwell_d;
      retry_q     <= retry_d;
      lock_meta_q <= cpll_lock;
      lock_sync_q <= lock_meta_q;
      done_meta_q <= tx_resetdone;
      done_sync_q <= done_meta_q;
      {cpll_pd, cpll_reset, gttx_reset, tx_userrdy, ready, fault} <= out_d;
    end
  end

  assign state     = state_q;
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_gtx_reset_seq.sv
// Directed bench for gtx_reset_seq with short dwell/timeout parameters.
module tb_gtx_reset_seq;

  logic       clk = 1'b0;
  logic       rst, start, cpll_lock, tx_resetdone;
  logic       cpll_pd, cpll_reset, gttx_reset, tx_userrdy, ready, fault;
  logic [7:0] retry_cnt;
  logic [2:0] state;
  logic [5:0] outs;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  assign outs = {cpll_pd, cpll_reset, gttx_reset, tx_userrdy, ready, fault};

  gtx_reset_seq #(
    .PD_CYCLES   (4),
    .RST_CYCLES  (2),
    .LOCK_TIMEOUT(20),
    .DONE_TIMEOUT(20),
    .MAX_RETRY   (3),
    .AUTO_START  (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .cpll_lock   (cpll_lock),
    .tx_resetdone(tx_resetdone),
    .cpll_pd     (cpll_pd),
    .cpll_reset  (cpll_reset),
    .gttx_reset  (gttx_reset),
    .tx_userrdy  (tx_userrdy),
    .ready       (ready),
    .fault       (fault),
    .retry_cnt   (retry_cnt),
    .state       (state)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves rst deasserted just after an edge; the next edge is E1.
  task automatic apply_reset(input logic lock, input logic done);
    rst = 1'b1; start = 1'b0; cpll_lock = lock; tx_resetdone = done;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (state === target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; cpll_lock = 1'b0; tx_resetdone = 1'b0;
    step(); step();
    n_checks++; if (state !== 3'd0) $display("FAIL rst_state: got %0d want 0", state); else n_pass++;
    n_checks++; if (outs !== 6'b111000) $display("FAIL rst_outs: got %b want 111000", outs); else n_pass++;
    n_checks++; if (retry_cnt !== 8'd0) $display("FAIL rst_retry: got %0d want 0", retry_cnt); else n_pass++;
    rst = 1'b0;
    step();
    n_checks++; if (state !== 3'd1) $display("FAIL autostart_state: got %0d want 1", state); else n_pass++;
  endtask

  task automatic test_happy_path();
    logic [2:0] exp;
    apply_reset(1'b0, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      step();
      exp = (i <= 4) ? 3'd1 : (i <= 6) ? 3'd2 : 3'd3;
      n_checks++;
      if (state !== exp) $display("FAIL hp_seq_e%0d: got %0d want %0d", i, state, exp);
      else n_pass++;
      if (i == 5) begin
        n_checks++; if (outs !== 6'b011000) $display("FAIL hp_cpllrst_outs: got %b want 011000", outs); else n_pass++;
      end
      if (i == 7) begin
        n_checks++; if (outs !== 6'b001000) $display("FAIL hp_waitlock_outs: got %b want 001000", outs); else n_pass++;
      end
    end
    cpll_lock = 1'b1;
    step(); step();
    n_checks++; if (state !== 3'd3) $display("FAIL hp_sync_latency: got %0d want 3", state); else n_pass++;
    step();
    n_checks++; if (state !== 3'd4) $display("FAIL hp_gtrst_state: got %0d want 4", state); else n_pass++;
    n_checks++; if (outs !== 6'b001000) $display("FAIL hp_gtrst_outs: got %b want 001000", outs); else n_pass++;
    step();
    n_checks++; if (state !== 3'd4) $display("FAIL hp_gtrst_dwell: got %0d want 4", state); else n_pass++;
    step();
    n_checks++; if (state !== 3'd5) $display("FAIL hp_waitdone_state: got %0d want 5", state); else n_pass++;
    n_checks++; if (outs !== 6'b000100) $display("FAIL hp_waitdone_outs: got %b want 000100", outs); else n_pass++;
    repeat (5) step();
    tx_resetdone = 1'b1;
    step(); step();
    n_checks++; if (state !== 3'd5) $display("FAIL hp_done_latency: got %0d want 5", state); else n_pass++;
    step();
    n_checks++; if (state !== 3'd6) $display("FAIL hp_ready_state: got %0d want 6", state); else n_pass++;
    n_checks++; if (outs !== 6'b000110) $display("FAIL hp_ready_outs: got %b want 000110", outs); else n_pass++;
    n_checks++; if (retry_cnt !== 8'd0) $display("FAIL hp_ready_retry: got %0d want 0", retry_cnt); else n_pass++;
  endtask

  task automatic test_lock_timeout();
    int bad;
    apply_reset(1'b0, 1'b0);
    repeat (26) step();
    n_checks++; if (state !== 3'd3) $display("FAIL lt_last_wait: got %0d want 3", state); else n_pass++;
    step();
    n_checks++; if (state !== 3'd1) $display("FAIL lt_retry1_state: got %0d want 1", state); else n_pass++;
    n_checks++; if (retry_cnt !== 8'd1) $display("FAIL lt_retry1_cnt: got %0d want 1", retry_cnt); else n_pass++;
    repeat (51) step();
    n_checks++; if (state !== 3'd3) $display("FAIL lt_third_wait: got %0d want 3", state); else n_pass++;
    n_checks++; if (retry_cnt !== 8'd2) $display("FAIL lt_retry2_cnt: got %0d want 2", retry_cnt); else n_pass++;
    step();
    n_checks++; if (state !== 3'd7) $display("FAIL lt_fault_state: got %0d want 7", state); else n_pass++;
    n_checks++; if (outs !== 6'b111001) $display("FAIL lt_fault_outs: got %b want 111001", outs); else n_pass++;
    n_checks++; if (retry_cnt !== 8'd3) $display("FAIL lt_fault_cnt: got %0d want 3", retry_cnt); else n_pass++;
    bad = 0;
    repeat (100) begin
      step();
      if (state !== 3'd7) bad++;
    end
    n_checks++; if (bad !== 0) $display("FAIL lt_fault_sticky: %0d cycles left state 7, want 0", bad); else n_pass++;
  endtask

  task automatic test_start_exits_fault();
    start = 1'b1;
    step();
    start = 1'b0;
    n_checks++; if (state !== 3'd1) $display("FAIL sf_state: got %0d want 1", state); else n_pass++;
    n_checks++; if (outs !== 6'b111000) $display("FAIL sf_outs: got %b want 111000", outs); else n_pass++;
    n_checks++; if (retry_cnt !== 8'd0) $display("FAIL sf_retry: got %0d want 0", retry_cnt); else n_pass++;
  endtask

  task automatic test_lock_vs_timeout();
    apply_reset(1'b0, 1'b0);
    repeat (24) step();
    cpll_lock = 1'b1;
    repeat (3) step();
    n_checks++; if (state !== 3'd4) $display("FAIL lvt_lock_wins: got %0d want 4", state); else n_pass++;
    n_checks++; if (retry_cnt !== 8'd0) $display("FAIL lvt_lock_retry: got %0d want 0", retry_cnt); else n_pass++;
    apply_reset(1'b0, 1'b0);
    repeat (25) step();
    cpll_lock = 1'b1;
    repeat (2) step();
    n_checks++; if (state !== 3'd1) $display("FAIL lvt_late_lock: got %0d want 1", state); else n_pass++;
    n_checks++; if (retry_cnt !== 8'd1) $display("FAIL lvt_late_retry: got %0d want 1", retry_cnt); else n_pass++;
  endtask

  task automatic test_start_priority();
    apply_reset(1'b0, 1'b0);
    repeat (26) step();
    start = 1'b1;
    step();
    start = 1'b0;
    n_checks++; if (state !== 3'd1) $display("FAIL sp_state: got %0d want 1", state); else n_pass++;
    n_checks++; if (retry_cnt !== 8'd0) $display("FAIL sp_retry: got %0d want 0", retry_cnt); else n_pass++;
    repeat (3) step();
    n_checks++; if (state !== 3'd1) $display("FAIL sp_pd_dwell: got %0d want 1", state); else n_pass++;
  endtask

  task automatic test_lock_drop();
    bit ok;
    apply_reset(1'b1, 1'b1);
    wait_state(3'd6, 40, ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL ld_bringup: got %0d want 1", ok); else n_pass++;
    cpll_lock = 1'b0;
    step(); step();
    n_checks++; if (state !== 3'd6) $display("FAIL ld_sync_latency: got %0d want 6", state); else n_pass++;
    step();
    n_checks++; if (state !== 3'd1) $display("FAIL ld_state: got %0d want 1", state); else n_pass++;
    n_checks++; if (ready !== 1'b0) $display("FAIL ld_ready: got %0d want 0", ready); else n_pass++;
    n_checks++; if (retry_cnt !== 8'd1) $display("FAIL ld_retry: got %0d want 1", retry_cnt); else n_pass++;
    cpll_lock = 1'b1;
    wait_state(3'd6, 40, ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL ld_recover: got %0d want 1", ok); else n_pass++;
    n_checks++; if (outs !== 6'b000110) $display("FAIL ld_recover_outs: got %b want 000110", outs); else n_pass++;
    n_checks++; if (retry_cnt !== 8'd1) $display("FAIL ld_recover_retry: got %0d want 1", retry_cnt); else n_pass++;
  endtask

  // Runs straight after test_lock_drop, so retry_cnt starts at 1.
  task automatic test_done_drop();
    bit ok;
    tx_resetdone = 1'b0;
    step(); step();
    n_checks++; if (state !== 3'd6) $display("FAIL dd_sync_latency: got %0d want 6", state); else n_pass++;
    step();
    n_checks++; if (state !== 3'd4) $display("FAIL dd_state: got %0d want 4", state); else n_pass++;
    n_checks++; if (outs !== 6'b001000) $display("FAIL dd_outs: got %b want 001000", outs); else n_pass++;
    n_checks++; if (retry_cnt !== 8'd1) $display("FAIL dd_retry: got %0d want 1", retry_cnt); else n_pass++;
    tx_resetdone = 1'b1;
    wait_state(3'd6, 20, ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL dd_recover: got %0d want 1", ok); else n_pass++;
    n_checks++; if (retry_cnt !== 8'd1) $display("FAIL dd_recover_retry: got %0d want 1", retry_cnt); else n_pass++;
  endtask

  task automatic test_rst_mid();
    bit ok;
    apply_reset(1'b1, 1'b1);
    wait_state(3'd6, 40, ok);
    cpll_lock = 1'b0;
    repeat (3) step();
    cpll_lock = 1'b1;
    tx_resetdone = 1'b0;
    wait_state(3'd5, 40, ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL rm_reach_waitdone: got %0d want 1", ok); else n_pass++;
    n_checks++; if (retry_cnt !== 8'd1) $display("FAIL rm_pre_retry: got %0d want 1", retry_cnt); else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++; if (state !== 3'd0) $display("FAIL rm_state: got %0d want 0", state); else n_pass++;
    n_checks++; if (outs !== 6'b111000) $display("FAIL rm_outs: got %b want 111000", outs); else n_pass++;
    n_checks++; if (retry_cnt !== 8'd0) $display("FAIL rm_retry: got %0d want 0", retry_cnt); else n_pass++;
    step();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_happy_path();
    test_lock_timeout();
    test_start_exits_fault();
    test_lock_vs_timeout();
    test_start_priority();
    test_lock_drop();
    test_done_drop();
    test_rst_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
